// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants and helpers for the ID/EX issue stage.
package rv32_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_TYPE_NONE   = 2'b00;
  localparam logic [1:0] ALU_TYPE_ARITH  = 2'b01;
  localparam logic [1:0] ALU_TYPE_BRANCH = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_LT  = 3'b111;

  // SLT and SLTU share one compare op; SRA executes as SRL on this ALU.
  function automatic logic [2:0] funct3_to_aluop(input logic [2:0] funct3);
    logic [2:0] op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_LT;
      3'b011:  op = ALU_LT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline register bus: driven by the issue stage, consumed by the ALU.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] ID_EX_A;
  logic [XLEN-1:0] ID_EX_BI;
  logic [XLEN-1:0] ID_EX_B;
  logic [XLEN-1:0] ID_EX_IMM;
  logic [31:0]     ID_EX_PC;
  logic [1:0]      alu_type_sel;
  logic [2:0]      alucontrol;
  logic [6:0]      alucontrol7;
  logic [4:0]      ID_EX_rd;
  logic            ID_EX_regwrite;
  logic            ID_EX_memread;
  logic            ID_EX_memwrite;
  logic            ID_EX_valid;

  modport master (
    output ID_EX_A, ID_EX_BI, ID_EX_B, ID_EX_IMM, ID_EX_PC,
           alu_type_sel, alucontrol, alucontrol7, ID_EX_rd,
           ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_valid
  );

  modport slave (
    input  ID_EX_A, ID_EX_BI, ID_EX_B, ID_EX_IMM, ID_EX_PC,
           alu_type_sel, alucontrol, alucontrol7, ID_EX_rd,
           ID_EX_regwrite, ID_EX_memread, ID_EX_memwrite, ID_EX_valid
  );
endinterface

// File: rtl/id_ex_stage_imm_gen.sv
// Immediate extraction and sign-extension for I, S and B formats; other formats yield 0.
module imm_gen
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]             opcode,
  input  logic [11:0]            ir_hi,   // IR[31:20]
  input  logic [4:0]             ir_lo,   // IR[11:7]
  output logic signed [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (opcode)
      OP_I, OP_LOAD: imm = {{(XLEN-12){ir_hi[11]}}, ir_hi};
      OP_STORE:      imm = {{(XLEN-12){ir_hi[11]}}, ir_hi[11:5], ir_lo};
      OP_BRANCH:     imm = {{(XLEN-13){ir_hi[11]}}, ir_hi[11], ir_lo[0],
                            ir_hi[10:5], ir_lo[4:1], 1'b0};
      default:       imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode/issue stage: operand forwarding, load-use detection and the ID/EX
// register feeding the execute ALU. Flush and stalls turn into bubbles; hold freezes.
module id_ex_stage
  import rv32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       IF_ID_IR,
  input  logic [31:0]       IF_ID_PC,
  input  logic              IF_ID_valid,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [4:0]        EX_MEM_rd,
  input  logic              EX_MEM_regwrite,
  input  logic [XLEN-1:0]   EX_MEM_ALU_OUT,
  input  logic [4:0]        MEM_WB_rd,
  input  logic              MEM_WB_regwrite,
  input  logic [XLEN-1:0]   MEM_WB_data,
  input  logic              flush,
  input  logic              hold,
  output logic              stall_if_id,
  id_ex_stage_if.master     ex_bus
);

  logic [6:0] opcode;
  logic [4:0] rd_f;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       uses_rs2;
  logic       load_use;
  logic       kill;

  logic signed [XLEN-1:0] imm;
  logic [XLEN-1:0]        op_a;
  logic [XLEN-1:0]        op_b;

  logic [XLEN-1:0] a_p0, bi_p0, b_p0, imm_p0;
  logic [31:0]     pc_p0;
  logic [1:0]      type_p0;
  logic [2:0]      ctl_p0;
  logic [6:0]      ctl7_p0;
  logic [4:0]      rd_p0;
  logic            rw_p0, mr_p0, mw_p0, vld_p0;

  logic [XLEN-1:0] a_p1, bi_p1, b_p1, imm_p1;
  logic [31:0]     pc_p1;
  logic [1:0]      type_p1;
  logic [2:0]      ctl_p1;
  logic [6:0]      ctl7_p1;
  logic [4:0]      rd_p1;
  logic            rw_p1, mr_p1, mw_p1, vld_p1;

  assign opcode   = IF_ID_IR[6:0];
  assign rd_f     = IF_ID_IR[11:7];
  assign funct3   = IF_ID_IR[14:12];
  assign rs1_addr = IF_ID_IR[19:15];
  assign rs2_addr = IF_ID_IR[24:20];
  assign funct7   = IF_ID_IR[31:25];

  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // rs1 is compared unconditionally; rs2 only when the format actually reads it.
  assign load_use = vld_p1 && mr_p1 && (rd_p1 != 5'd0) &&
                    ((rd_p1 == rs1_addr) || (uses_rs2 && (rd_p1 == rs2_addr)));

  assign stall_if_id = load_use && IF_ID_valid && !flush && !hold;
  assign kill        = flush || load_use || !IF_ID_valid;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .opcode (opcode),
    .ir_hi  (IF_ID_IR[31:20]),
    .ir_lo  (IF_ID_IR[11:7]),
    .imm    (imm)
  );

  // Forwarding: newest producer (EX/MEM) beats WB; x0 is hard zero.
  always_comb begin
    op_a = rs1_data;
    if (rs1_addr == 5'd0)
      op_a = '0;
    else if (FWD_EN && EX_MEM_regwrite && (EX_MEM_rd == rs1_addr))
      op_a = EX_MEM_ALU_OUT;
    else if (FWD_EN && MEM_WB_regwrite && (MEM_WB_rd == rs1_addr))
      op_a = MEM_WB_data;

    op_b = rs2_data;
    if (rs2_addr == 5'd0)
      op_b = '0;
    else if (FWD_EN && EX_MEM_regwrite && (EX_MEM_rd == rs2_addr))
      op_b = EX_MEM_ALU_OUT;
    else if (FWD_EN && MEM_WB_regwrite && (MEM_WB_rd == rs2_addr))
      op_b = MEM_WB_data;
  end

  // Decode into next ID/EX contents; everything defaults to a zeroed bubble.
  always_comb begin
    a_p0    = '0;
    bi_p0   = '0;
    b_p0    = '0;
    imm_p0  = '0;
    pc_p0   = '0;
    type_p0 = ALU_TYPE_NONE;
    ctl_p0  = ALU_ADD;
    ctl7_p0 = '0;
    rd_p0   = '0;
    rw_p0   = 1'b0;
    mr_p0   = 1'b0;
    mw_p0   = 1'b0;
    vld_p0  = 1'b0;

    if (!kill) begin
      case (opcode)
        OP_R: begin
          vld_p0  = 1'b1;
          type_p0 = ALU_TYPE_ARITH;
          ctl_p0  = funct3_to_aluop(funct3);
          ctl7_p0 = funct7;
          bi_p0   = op_b;
          rd_p0   = rd_f;
          rw_p0   = (rd_f != 5'd0);
        end
        OP_I: begin
          vld_p0  = 1'b1;
          type_p0 = ALU_TYPE_ARITH;
          ctl_p0  = funct3_to_aluop(funct3);
          bi_p0   = imm;
          rd_p0   = rd_f;
          rw_p0   = (rd_f != 5'd0);
        end
        OP_LOAD: begin
          vld_p0  = 1'b1;
          type_p0 = ALU_TYPE_ARITH;
          ctl_p0  = ALU_ADD;
          bi_p0   = imm;
          rd_p0   = rd_f;
          rw_p0   = (rd_f != 5'd0);
          mr_p0   = 1'b1;
        end
        OP_STORE: begin
          vld_p0  = 1'b1;
          type_p0 = ALU_TYPE_ARITH;
          ctl_p0  = ALU_ADD;
          bi_p0   = imm;
          mw_p0   = 1'b1;
        end
        OP_BRANCH: begin
          vld_p0  = 1'b1;
          type_p0 = ALU_TYPE_BRANCH;
          ctl_p0  = funct3;
          bi_p0   = op_b;
        end
        default: ;
      endcase

      if (vld_p0) begin
        a_p0   = op_a;
        b_p0   = op_b;
        imm_p0 = imm;
        pc_p0  = IF_ID_PC;
      end
    end
  end

  // ---- ID/EX register boundary ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p1    <= '0;
      bi_p1   <= '0;
      b_p1    <= '0;
      imm_p1  <= '0;
      pc_p1   <= '0;
      type_p1 <= ALU_TYPE_NONE;
      ctl_p1  <= '0;
      ctl7_p1 <= '0;
      rd_p1   <= '0;
      rw_p1   <= 1'b0;
      mr_p1   <= 1'b0;
      mw_p1   <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (!hold) begin
      a_p1    <= a_p0;
      bi_p1   <= bi_p0;
      b_p1    <= b_p0;
      imm_p1  <= imm_p0;
      pc_p1   <= pc_p0;
      type_p1 <= type_p0;
      ctl_p1  <= ctl_p0;
      ctl7_p1 <= ctl7_p0;
      rd_p1   <= rd_p0;
      rw_p1   <= rw_p0;
      mr_p1   <= mr_p0;
      mw_p1   <= mw_p0;
      vld_p1  <= vld_p0;
    end
  end

  assign ex_bus.ID_EX_A        = a_p1;
  assign ex_bus.ID_EX_BI       = bi_p1;
  assign ex_bus.ID_EX_B        = b_p1;
  assign ex_bus.ID_EX_IMM      = imm_p1;
  assign ex_bus.ID_EX_PC       = pc_p1;
  assign ex_bus.alu_type_sel   = type_p1;
  assign ex_bus.alucontrol     = ctl_p1;
  assign ex_bus.alucontrol7    = ctl7_p1;
  assign ex_bus.ID_EX_rd       = rd_p1;
  assign ex_bus.ID_EX_regwrite = rw_p1;
  assign ex_bus.ID_EX_memread  = mr_p1;
  assign ex_bus.ID_EX_memwrite = mw_p1;
  assign ex_bus.ID_EX_valid    = vld_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a behavioural issue-stage model predicts each
// cycle's ID/EX contents; a monitor compares them after every rising edge.
module tb_id_ex_stage;

  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_L = 7'b0000011;
  localparam logic [6:0] OPC_S = 7'b0100011, OPC_B = 7'b1100011;

  typedef struct packed {
    logic [31:0] a, bi, b, imm, pc;
    logic [1:0]  typ;
    logic [2:0]  ctl;
    logic [6:0]  ctl7;
    logic [4:0]  rd;
    logic        rw, mr, mw, vld;
  } ex_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] ir, pc;
  logic        ifv;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1d, rs2d;
  logic [4:0]  exrd, wbrd;
  logic        exrw, wbrw;
  logic [31:0] exv, wbv;
  logic        flush, hold;
  logic        stall;

  id_ex_stage_if #(.XLEN(32)) ex_bus ();

  id_ex_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .IF_ID_IR        (ir),
    .IF_ID_PC        (pc),
    .IF_ID_valid     (ifv),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_data        (rs1d),
    .rs2_data        (rs2d),
    .EX_MEM_rd       (exrd),
    .EX_MEM_regwrite (exrw),
    .EX_MEM_ALU_OUT  (exv),
    .MEM_WB_rd       (wbrd),
    .MEM_WB_regwrite (wbrw),
    .MEM_WB_data     (wbv),
    .flush           (flush),
    .hold            (hold),
    .stall_if_id     (stall),
    .ex_bus          (ex_bus)
  );

  int  n_tests = 0;
  int  n_fail  = 0;
  ex_t exp_q[$];
  ex_t mst;
  int  aluop_tbl [8] = '{0, 5, 7, 7, 3, 4, 2, 1};

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  function automatic ex_t dut_now();
    ex_t d;
    d.a    = ex_bus.ID_EX_A;        d.bi  = ex_bus.ID_EX_BI;
    d.b    = ex_bus.ID_EX_B;        d.imm = ex_bus.ID_EX_IMM;
    d.pc   = ex_bus.ID_EX_PC;       d.typ = ex_bus.alu_type_sel;
    d.ctl  = ex_bus.alucontrol;     d.ctl7 = ex_bus.alucontrol7;
    d.rd   = ex_bus.ID_EX_rd;       d.rw  = ex_bus.ID_EX_regwrite;
    d.mr   = ex_bus.ID_EX_memread;  d.mw  = ex_bus.ID_EX_memwrite;
    d.vld  = ex_bus.ID_EX_valid;
    return d;
  endfunction

  // Value a source register would read after forwarding.
  function automatic logic [31:0] src_val(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return 32'd0;
    if (exrw && exrd == r) return exv;
    if (wbrw && wbrd == r) return wbv;
    return rf;
  endfunction

  function automatic ex_t model_next(input ex_t cur, output logic exp_stall);
    ex_t n;
    logic [6:0] op;
    logic [4:0] r1, r2, rd;
    logic uses2, hz;
    int iimm, simm, bimm;
    op = ir[6:0]; rd = ir[11:7]; r1 = ir[19:15]; r2 = ir[24:20];
    uses2 = (op == OPC_R) || (op == OPC_S) || (op == OPC_B);
    hz = cur.vld && cur.mr && cur.rd != 0 && (cur.rd == r1 || (uses2 && cur.rd == r2));
    exp_stall = hz && ifv && !flush && !hold;
    if (hold) return cur;
    n = '0;
    if (flush || hz || !ifv) return n;
    iimm = int'($signed(ir[31:20]));
    simm = int'($signed({ir[31:25], ir[11:7]}));
    bimm = int'($signed({ir[31], ir[7], ir[30:25], ir[11:8]})) * 2;
    n.vld = 1'b1;
    n.a   = src_val(r1, rs1d);
    n.b   = src_val(r2, rs2d);
    n.pc  = pc;
    case (op)
      OPC_R: begin
        n.typ = 2'b01; n.bi = n.b; n.ctl = 3'(aluop_tbl[ir[14:12]]);
        n.ctl7 = ir[31:25]; n.rd = rd; n.rw = (rd != 0);
      end
      OPC_I: begin
        n.typ = 2'b01; n.bi = iimm; n.imm = iimm; n.ctl = 3'(aluop_tbl[ir[14:12]]);
        n.rd = rd; n.rw = (rd != 0);
      end
      OPC_L: begin
        n.typ = 2'b01; n.bi = iimm; n.imm = iimm; n.rd = rd; n.rw = (rd != 0); n.mr = 1'b1;
      end
      OPC_S: begin
        n.typ = 2'b01; n.bi = simm; n.imm = simm; n.mw = 1'b1;
      end
      OPC_B: begin
        n.typ = 2'b10; n.bi = n.b; n.imm = bimm; n.ctl = ir[14:12];
      end
      default: n = '0;
    endcase
    return n;
  endfunction

  // Called just after a falling edge with inputs already set.
  task automatic step();
    ex_t nxt;
    logic es;
    #1;
    nxt = model_next(mst, es);
    chk("stall_if_id", {191'd0, stall}, {191'd0, es});
    chk("rs_addr", {182'd0, rs1_addr, rs2_addr}, {182'd0, ir[19:15], ir[24:20]});
    exp_q.push_back(nxt);
    mst = nxt;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, r2, r1, f3, rd, OPC_R};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, r1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3);
    return {imm[11:5], r2, r1, f3, imm[4:0], OPC_S};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], OPC_B};
  endfunction

  function automatic logic [4:0] rreg();
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] t;
    logic [6:0]  f7;
    case ($urandom_range(0, 2))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0: t = enc_r(f7, rreg(), rreg(), 3'($urandom), rreg());
      1: t = enc_i(12'($urandom), rreg(), 3'($urandom), rreg(), OPC_I);
      2: t = enc_i(12'($urandom), rreg(), 3'b010, rreg(), OPC_L);
      3: t = enc_s(12'($urandom), rreg(), rreg(), 3'b010);
      4: t = enc_b(13'($urandom), rreg(), rreg(), 3'($urandom));
      default: begin
        t = $urandom;
        t[6:0] = 7'b1110111;
      end
    endcase
    return t;
  endfunction

  task automatic set_fwd(input logic [4:0] er, input logic ew, input logic [31:0] ev,
                         input logic [4:0] wr, input logic ww, input logic [31:0] wv);
    exrd = er; exrw = ew; exv = ev; wbrd = wr; wbrw = ww; wbv = wv;
  endtask

  initial begin : monitor
    ex_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("id_ex_bus", {11'd0, dut_now()}, {11'd0, e});
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    mst = '0;
    rst_n = 1'b0; ir = $urandom; pc = 32'h100; ifv = 1'b1;
    rs1d = $urandom; rs2d = $urandom; flush = 1'b0; hold = 1'b0;
    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    repeat (3) @(negedge clk);
    chk("reset_bus", {11'd0, dut_now()}, 192'd0);
    chk("reset_stall", {191'd0, stall}, 192'd0);

    rst_n = 1'b1;
    ir = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3); rs1d = 5; rs2d = 7; step();

    ir = enc_r(7'h20, 5'd3, 5'd3, 3'b000, 5'd4); pc = 32'h104;
    set_fwd(5'd3, 1'b1, 32'h10, 5'd3, 1'b1, 32'h20); step();
    exrd = 5'd0; step();

    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    ir = enc_i(12'd4, 5'd1, 3'b010, 5'd5, OPC_L); rs1d = 32'h100; pc = 32'h108; step();
    ir = enc_i(12'd1, 5'd5, 3'b000, 5'd6, OPC_I); pc = 32'h10C; rs1d = 32'h999; step();
    set_fwd(5'd0, 1'b0, 32'd0, 5'd5, 1'b1, 32'h55); step();

    set_fwd(5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0);
    ir = enc_b(-13'sd8, 5'd2, 5'd1, 3'b000); pc = 32'h110; rs1d = 3; rs2d = 3; step();
    ir = enc_i(12'hF, 5'd1, 3'b110, 5'd7, OPC_I); pc = 32'h114; flush = 1'b1; step();
    flush = 1'b0;

    ir = enc_i(12'd0, 5'd1, 3'b010, 5'd5, OPC_L); pc = 32'h118; step();
    ir = enc_i(12'd1, 5'd5, 3'b000, 5'd6, OPC_I); pc = 32'h11C; flush = 1'b1; step();
    flush = 1'b0;

    ir = enc_i(12'd8, 5'd2, 3'b010, 5'd5, OPC_L); pc = 32'h120; step();
    ir = enc_r(7'h00, 5'd5, 5'd1, 3'b111, 5'd6); pc = 32'h124; hold = 1'b1;
    repeat (3) step();
    hold = 1'b0; step(); step();

    ir = enc_i(12'd9, 5'd0, 3'b000, 5'd0, OPC_I); pc = 32'h128;
    set_fwd(5'd0, 1'b1, 32'hDEAD, 5'd0, 1'b1, 32'hBEEF); step();
    ir = 32'hFFFF_FFFF; step();
    ir = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3); ifv = 1'b0; step();
    ifv = 1'b1;

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_bus", {11'd0, dut_now()}, 192'd0);
        chk("midrun_reset_stall", {191'd0, stall}, 192'd0);
        mst = '0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      ir    = rand_ir();
      pc    = $urandom & 32'hFFFF_FFFC;
      ifv   = ($urandom_range(0, 7) != 0);
      rs1d  = $urandom;
      rs2d  = $urandom;
      set_fwd(rreg(), 1'($urandom), $urandom, rreg(), 1'($urandom), $urandom);
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      step();
    end

    flush = 1'b0; hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 192'(exp_q.size()), 192'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
